key_debounce_multi: RTL and testbench

//  Debounces KEY_NUM independent mechanical keys (active-low inputs) in one block.

---
 rtl/key_timing_pkg.sv | 24 ++
 rtl/key_debounce_ch.sv | 96 +++++++++
 rtl/key_debounce_multi.sv | 43 ++++
 tb/tb_key_debounce_multi.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/key_timing_pkg.sv
// Key timing constants shared by all key-handling blocks.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// CLK_FREQ_HZ    system clock frequency the defaults are derived from
// DEBOUNCE_20MS  debounce stable time in clocks, minus 1
// LONG_1S        long-press hold time in clocks, minus 1
package key_timing_pkg;

    localparam int unsigned CLK_FREQ_HZ = 50_000_000;

    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_FREQ_HZ / 1000) * ms;
    endfunction

    // Width of an unsigned counter that must reach max_val; never below 1 bit.
    function automatic int key_cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int unsigned DEBOUNCE_20MS = ms_to_cycles(20) - 1;
    localparam int unsigned LONG_1S       = ms_to_cycles(1000) - 1;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce counter, long-press counter.
// Latency: press/release pulse on the CNT_MAX+3th edge after a stable input change.
// Backpressure: none; pulses are single-cycle and cannot be stalled.
//
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   key_in              raw pin, asynchronous, 0 = pressed
//   key_state           debounced level, 1 = pressed
//   key_press           1-cycle pulse on debounced press
//   key_release         1-cycle pulse on debounced release
//   key_long            1-cycle pulse once per press after LONG_MAX+1 clocks held
module key_debounce_ch
    import key_timing_pkg::*;
#(
    parameter int unsigned CNT_MAX  = DEBOUNCE_20MS,
    parameter int unsigned LONG_MAX = LONG_1S
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int CNT_W  = key_cnt_width(CNT_MAX);
    localparam int LONG_W = key_cnt_width(LONG_MAX);

    localparam logic [CNT_W-1:0]  CNT_TOP  = CNT_W'(CNT_MAX);
    localparam logic [LONG_W-1:0] LONG_TOP = LONG_W'(LONG_MAX);

    logic              key_s1;
    logic              key_s2;
    logic              stab;       // debounced level, 1 = pressed
    logic [CNT_W-1:0]  cnt;
    logic [LONG_W-1:0] lcnt;
    logic              long_done;  // long pulse already issued for this press

    logic lvl_pressed;
    logic change;
    logic cnt_done;
    logic rel_evt;

    assign lvl_pressed = ~key_s2;
    assign change      = (lvl_pressed != stab);
    assign cnt_done    = change && (cnt == CNT_TOP);
    // A release landing on the same edge as the long-press threshold suppresses key_long.
    assign rel_evt     = cnt_done && !lvl_pressed;

    assign key_state = stab;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_s1      <= 1'b1;
            key_s2      <= 1'b1;
            stab        <= 1'b0;
            cnt         <= '0;
            lcnt        <= '0;
            long_done   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_s1      <= key_in;
            key_s2      <= key_s1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;

            // Debounce: any return to the current stable level restarts timing.
            if (!change) begin
                cnt <= '0;
            end else if (cnt_done) begin
                cnt         <= '0;
                stab        <= lvl_pressed;
                key_press   <= lvl_pressed;
                key_release <= ~lvl_pressed;
            end else if (cnt < CNT_TOP) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Long press: lcnt saturates at LONG_TOP; long_done guarantees a single pulse.
            if (!stab) begin
                lcnt      <= '0;
                long_done <= 1'b0;
            end else if (lcnt < LONG_TOP) begin
                lcnt <= lcnt + LONG_W'(1);
            end else if (!long_done && !rel_evt) begin
                key_long  <= 1'b1;
                long_done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_debounce_multi.sv
// Debounces KEY_NUM independent active-low keys; one key_debounce_ch per key.
// Latency: press/release pulse on the CNT_MAX+3th edge after a stable input change.
// Backpressure: none; all outputs are free-running pulses/levels.
//
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   key_in      [KEY_NUM]  raw pins, 0 = pressed
//   key_state   [KEY_NUM]  debounced level, 1 = pressed
//   key_press   [KEY_NUM]  1-cycle press pulses
//   key_release [KEY_NUM]  1-cycle release pulses
//   key_long    [KEY_NUM]  1-cycle long-press pulses
module key_debounce_multi
    import key_timing_pkg::*;
#(
    parameter int unsigned KEY_NUM  = 4,
    parameter int unsigned CNT_MAX  = DEBOUNCE_20MS,
    parameter int unsigned LONG_MAX = LONG_1S
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_debounce_ch #(
            .CNT_MAX  (CNT_MAX),
            .LONG_MAX (LONG_MAX)
        ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst_n   (sys_rst_n),
            .key_in      (key_in[i]),
            .key_state   (key_state[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
module tb_key_debounce_multi;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] key_in    = 4'hF;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;

    key_debounce_multi #(
        .KEY_NUM  (4),
        .CNT_MAX  (9),
        .LONG_MAX (49)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_in      (key_in),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        string      name;
        logic [3:0] key;
        int         edges;
        logic [15:0] exp;   // {state, press, release, long}
    } vec_t;

    vec_t tbl[$];

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;

    int press_cnt[4];
    int rel_cnt[4];
    int long_cnt[4];
    int press_edge[4];
    int rel_edge[4];
    int long_edge[4];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] outs();
        return {key_state, key_press, key_release, key_long};
    endfunction

    // Advance one edge, sample 1 time unit later and log every pulse.
    task automatic step();
        @(posedge sys_clk);
        #1;
        edge_n++;
        for (int c = 0; c < 4; c++) begin
            if (key_press[c])   begin press_cnt[c]++; press_edge[c] = edge_n; end
            if (key_release[c]) begin rel_cnt[c]++;   rel_edge[c]   = edge_n; end
            if (key_long[c])    begin long_cnt[c]++;  long_edge[c]  = edge_n; end
        end
    endtask

    task automatic clear_stats();
        for (int c = 0; c < 4; c++) begin
            press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
            press_edge[c] = -1; rel_edge[c] = -1; long_edge[c] = -1;
        end
    endtask

    task automatic add(input string n, input logic [3:0] k, input int e, input logic [15:0] x);
        vec_t v;
        v.name = n; v.key = k; v.edges = e; v.exp = x;
        tbl.push_back(v);
    endtask

    initial begin
        int e0;
        int pe;

        // single key 0: press on edge 12, release 12 edges after the input returns high
        add("t2_pre_press",   4'hE, 11, 16'h0000);
        add("t2_press",       4'hE,  1, 16'h1100);
        add("t2_press_end",   4'hE,  1, 16'h1000);
        add("t2_pre_release", 4'hF, 11, 16'h1000);
        add("t2_release",     4'hF,  1, 16'h0010);
        add("t2_idle",        4'hF,  1, 16'h0000);
        // key 3 held 30 cycles: press and release, no long
        add("t5_pre_press",   4'h7, 11, 16'h0000);
        add("t5_press",       4'h7,  1, 16'h8800);
        add("t5_hold",        4'h7, 18, 16'h8000);
        add("t5_pre_release", 4'hF, 11, 16'h8000);
        add("t5_release",     4'hF,  1, 16'h0080);
        add("t5_idle",        4'hF,  1, 16'h0000);
        // all keys together: channels pulse in the same cycle
        add("all_pre_press",  4'h0, 11, 16'h0000);
        add("all_press",      4'h0,  1, 16'hFF00);
        add("all_press_end",  4'h0,  1, 16'hF000);
        add("all_pre_rel",    4'hF, 11, 16'hF000);
        add("all_release",    4'hF,  1, 16'h00F0);
        add("all_idle",       4'hF,  1, 16'h0000);

        clear_stats();

        // 1. reset and idle
        sys_rst_n = 1'b0;
        key_in    = 4'hF;
        repeat (3) step();
        check("rst_outputs", outs(), 16'h0000);
        sys_rst_n = 1'b1;
        repeat (100) step();
        check("idle_outputs", outs(), 16'h0000);
        check("idle_no_pulses", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]
                                + rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 0);

        // 2/5/simultaneous: table
        clear_stats();
        foreach (tbl[i]) begin
            key_in = tbl[i].key;
            repeat (tbl[i].edges) step();
            check(tbl[i].name, outs(), tbl[i].exp);
        end
        check("tbl_press_cnt0", press_cnt[0], 2);
        check("tbl_press_cnt1", press_cnt[1], 1);
        check("tbl_press_cnt3", press_cnt[3], 2);
        check("tbl_rel_cnt2",   rel_cnt[2],   1);
        check("tbl_no_long",    long_cnt[0] + long_cnt[1] + long_cnt[2] + long_cnt[3], 0);

        // 3. bounce on key 1: 4-cycle toggles never reach the debounce time
        clear_stats();
        for (int k = 0; k < 20; k++) begin
            key_in[1] = ~key_in[1];
            repeat (4) step();
        end
        repeat (20) step();
        check("bounce_press",   press_cnt[1], 0);
        check("bounce_release", rel_cnt[1],   0);
        check("bounce_state",   key_state[1], 0);

        // 4. long press on key 2
        clear_stats();
        key_in[2] = 1'b0;
        e0 = edge_n;
        repeat (120) step();
        check("long_press_lat",  press_edge[2] - e0, 12);
        check("long_count",      long_cnt[2], 1);
        check("long_lat",        long_edge[2] - press_edge[2], 50);
        check("long_state_held", key_state[2], 1);
        key_in[2] = 1'b1;
        e0 = edge_n;
        repeat (20) step();
        check("long_rel_lat",   rel_edge[2] - e0, 12);
        check("long_rel_count", rel_cnt[2], 1);
        check("long_after_rel", long_cnt[2], 1);
        check("long_state_rel", key_state[2], 0);

        // release landing exactly on the long threshold (k=38) vs one edge later (k=39)
        for (int k = 38; k <= 39; k++) begin
            clear_stats();
            key_in[1] = 1'b0;
            e0 = edge_n;
            repeat (12) step();
            pe = e0 + 12;
            check("race_press_lat", press_edge[1], pe);
            repeat (k) step();
            key_in[1] = 1'b1;
            repeat (20) step();
            check("race_rel_edge", rel_edge[1], pe + k + 12);
            check("race_long_cnt", long_cnt[1], (k == 39) ? 1 : 0);
        end

        // 6. reset during debounce of key 0
        clear_stats();
        key_in[0] = 1'b0;
        repeat (7) step();
        sys_rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", outs(), 16'h0000);
        repeat (5) step();
        check("rst_mid_no_press", press_cnt[0], 0);
        sys_rst_n = 1'b1;
        e0 = edge_n;
        repeat (20) step();
        check("rst_held_press_lat", press_edge[0] - e0, 12);
        check("rst_held_press_cnt", press_cnt[0], 1);
        check("rst_held_state",     key_state[0], 1);

        // reset while key 0 is debounced-pressed: state clears, no release pulse
        sys_rst_n = 1'b0;
        #1;
        check("rst_clears_state", key_state, 4'h0);
        key_in = 4'hF;
        repeat (3) step();
        sys_rst_n = 1'b1;
        repeat (20) step();
        check("rst_no_release", rel_cnt[0], 0);
        check("rst_final_idle", outs(), 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
